// File: rtl/inv_table_lookup_if.sv
// -----------------------------------------------------------------------------
// inv_table_lookup_if
//   Bundles the column input handshake and the lookup-result output handshake
//   of inv_table_lookup into one interface.
//
//   Signals:
//     in_valid  - input column valid
//     in_ready  - block can accept a column this cycle
//     in_last   - last-round mode for this column (InvSubBytes only)
//     state     - column {b0,b1,b2,b3}, b0 = state[31:24]
//     out_valid - p0..p3 / out_last valid
//     out_ready - consumer takes the output this cycle
//     out_last  - in_last value that travelled with this column
//     p0..p3    - rotated inverse T-table words (or bare inverse S-box bytes)
//
//   Modports:
//     master - the round controller side (drives the column, consumes results)
//     slave  - the lookup block side
// -----------------------------------------------------------------------------
interface inv_table_lookup_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] state;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;

    modport master (
        output in_valid,
        output in_last,
        output state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_last,
        input  p0,
        input  p1,
        input  p2,
        input  p3
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_last,
        output p0,
        output p1,
        output p2,
        output p3
    );
endinterface

// File: rtl/inv_table_lookup.sv
// -----------------------------------------------------------------------------
// inv_table_lookup
//   Pipelined inverse-cipher column lookup for the AES decryption datapath.
//   Takes one 32-bit state column and returns four rotated inverse T-table
//   words Td(b0), rotr8(Td(b1)), rotr16(Td(b2)), rotr24(Td(b3)), where
//   Td(b) = {0e*s, 09*s, 0d*s, 0b*s} and s = InvSbox(b). In last-round mode
//   each word instead carries only the bare inverse S-box byte in its lane.
//
//   Pipeline:
//     stage 1 : v1, last1, s(b0..b3)  (inverse S-box)
//     stage 2 : v2, last2, p0..p3     (InvMixColumns multiples + rotation)
//   Both stages use valid/ready flow control so the downstream round
//   controller may stall without losing or duplicating columns.
//
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset, clears both stages
//     bus - inv_table_lookup_if.slave (column in, lookup words out)
// -----------------------------------------------------------------------------
module inv_table_lookup (
    input  logic              clk,
    input  logic              rst,
    inv_table_lookup_if.slave bus
);

    // -------------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11b
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (Fermat). The addition chain reuses
    // intermediate powers so only 11 multiplies are needed; 0 maps to 0
    // naturally, which matches the S-box convention.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    // Inverse of the S-box affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // InvSbox(b) = inverse(inv_affine(b)); bit-identical to the FIPS-197 table.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(inv_affine(b));
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic adv1;
    logic adv2;

    logic        v1_reg;
    logic        last1_reg;
    logic [7:0]  sb1_reg [4];
    logic [7:0]  sb_next [4];

    logic        v2_reg;
    logic        last2_reg;
    logic [31:0] p_reg   [4];
    logic [31:0] p_next  [4];

    // A stage may advance when it is empty or the stage after it is moving.
    // Because adv1 depends on out_ready combinationally, a full pipeline can
    // hand a column downstream and take a new one on the same edge.
    assign adv2 = !v2_reg || bus.out_ready;
    assign adv1 = !v1_reg || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_reg;
    assign bus.out_last  = last2_reg;
    assign bus.p0        = p_reg[0];
    assign bus.p1        = p_reg[1];
    assign bus.p2        = p_reg[2];
    assign bus.p3        = p_reg[3];

    // -------------------------------------------------------------------------
    // Per-lane datapath
    //   Lane gi handles byte b<gi> = state[31-8*gi -: 8].
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int LAST_SHIFT = 8 * (3 - gi);

        logic [7:0]  s;
        logic [7:0]  s_x2;
        logic [7:0]  s_x4;
        logic [7:0]  s_x8;
        logic [31:0] td;
        logic [63:0] td_dbl;
        logic [31:0] last_word;

        // Stage 1: inverse S-box of the incoming byte.
        assign sb_next[gi] = inv_sbox(bus.state[31 - 8*gi -: 8]);

        // Stage 2: InvMixColumns multiples from the registered S-box byte.
        assign s    = sb1_reg[gi];
        assign s_x2 = xtime(s);
        assign s_x4 = xtime(s_x2);
        assign s_x8 = xtime(s_x4);

        // {0e*s, 09*s, 0d*s, 0b*s}
        assign td = {s_x8 ^ s_x4 ^ s_x2,
                     s_x8 ^ s,
                     s_x8 ^ s_x4 ^ s,
                     s_x8 ^ s_x2 ^ s};

        // Rotate right by 8*gi: slicing a doubled copy avoids a variable shift.
        assign td_dbl = {td, td};

        // Last round: the bare byte sits in its own lane, other bytes zero.
        assign last_word = {24'h000000, s} << LAST_SHIFT;

        assign p_next[gi] = last1_reg ? last_word : td_dbl[8*gi +: 32];
    end

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sb1_reg[i] <= 8'h00;
            end
        end else if (adv1) begin
            // in_ready equals adv1 here, so in_valid alone marks acceptance.
            v1_reg <= bus.in_valid;
            if (bus.in_valid) begin
                last1_reg <= bus.in_last;
                for (int i = 0; i < 4; i++) begin
                    sb1_reg[i] <= sb_next[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 registers
    //   Held while stalled, so p0..p3 and out_last are stable under
    //   out_valid & !out_ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            last2_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                p_reg[i] <= 32'h0000_0000;
            end
        end else if (adv2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                last2_reg <= last1_reg;
                for (int i = 0; i < 4; i++) begin
                    p_reg[i] <= p_next[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_table_lookup.sv
// -----------------------------------------------------------------------------
// tb_inv_table_lookup
//   Directed-vector bench for inv_table_lookup: hand-computed vector table,
//   full-range streams scored against an independent GF(2^8) model, a
//   backpressure sequence and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_inv_table_lookup;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inv_table_lookup_if bus ();

    inv_table_lookup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] fwd_sb [256];
    logic [7:0] inv_sb [256];

    typedef struct {
        logic [31:0] state;
        logic        last;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
    } vec_t;

    typedef struct {
        logic [31:0] state;
        logic        last;
    } col_t;

    typedef struct {
        logic [31:0]  state;
        logic         last;
        logic [127:0] p;
    } exp_t;

    vec_t vecs [8];
    col_t src_q [$];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Shift-and-add multiply, reducing as the multiplicand overflows.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box by brute-force inverse and forward affine; inverse S-box
    // is then the permutation inverse of that table.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] xb;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            s = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
            fwd_sb[x] = s;
            inv_sb[s] = xb;
        end
    endtask

    function automatic logic [127:0] model(input logic [31:0] st, input logic last);
        logic [127:0] r;
        logic [7:0]   s;
        logic [31:0]  td;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = inv_sb[st[31 - 8*i -: 8]];
            if (last) begin
                w = {24'h0, s} << (8 * (3 - i));
            end else begin
                td = {gmul(s, 8'h0e), gmul(s, 8'h09), gmul(s, 8'h0d), gmul(s, 8'h0b)};
                case (i)
                    0:       w = td;
                    1:       w = {td[7:0],  td[31:8]};
                    2:       w = {td[15:0], td[31:16]};
                    default: w = {td[23:0], td[31:24]};
                endcase
            end
            r[127 - 32*i -: 32] = w;
        end
        return r;
    endfunction

    // Cycle-based stream driver/monitor. Columns come from src_q; expected
    // results are pushed on acceptance and popped on consumption.
    task automatic run_stream(input int stall_at, input int stall_len, input bit fwd_chk,
                              output int cycles);
        int           cyc;
        bit           held_v;
        logic [128:0] held;
        logic [127:0] cur;
        exp_t         e;
        cyc    = 0;
        held_v = 1'b0;
        held   = '0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            bus.out_ready = (cyc < stall_at) || (cyc >= stall_at + stall_len);
            if (src_q.size() != 0) begin
                bus.in_valid = 1'b1;
                bus.state    = src_q[0].state;
                bus.in_last  = src_q[0].last;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            cur = {bus.p0, bus.p1, bus.p2, bus.p3};
            // Only a full pipeline facing a stalled consumer refuses input.
            check("in_ready", bus.in_ready, !(exp_q.size() == 2 && !bus.out_ready));
            if (held_v) begin
                check("stall_hold", {bus.out_valid, bus.out_last, cur}, {1'b1, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL extra_out: got %0h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_p", {bus.out_last, cur}, {e.last, e.p});
                    if (fwd_chk) check("fwd_sbox", fwd_sb[bus.p3[7:0]], e.state[7:0]);
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = {bus.out_last, cur};
            if (bus.in_valid && bus.in_ready) begin
                e.state = bus.state;
                e.last  = bus.in_last;
                e.p     = model(bus.state, bus.in_last);
                exp_q.push_back(e);
                void'(src_q.pop_front());
            end
            cyc++;
        end
        if (cyc >= 3000) begin
            n_vec++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d pending want 0", exp_q.size());
        end
        cycles = cyc;
    endtask

    initial begin
        int   cycles;
        col_t c;

        // Hand-computed vectors: {state, last, p0, p1, p2, p3}
        vecs[0] = '{32'h00637c00, 1'b0, 32'h51f4a750, 32'h00000000, 32'h0d0b0e09, 32'hf4a75051};
        vecs[1] = '{32'h00637c16, 1'b1, 32'h52000000, 32'h00000000, 32'h00000100, 32'h000000ff};
        vecs[2] = '{32'h63636363, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3] = '{32'h7c7c7c7c, 1'b0, 32'h0e090d0b, 32'h0b0e090d, 32'h0d0b0e09, 32'h090d0b0e};
        vecs[4] = '{32'h01000000, 1'b0, 32'h7e416553, 32'h5051f4a7, 32'ha75051f4, 32'hf4a75051};
        vecs[5] = '{32'h16161616, 1'b1, 32'hff000000, 32'h00ff0000, 32'h0000ff00, 32'h000000ff};
        vecs[6] = '{32'hffffffff, 1'b1, 32'h7d000000, 32'h007d0000, 32'h00007d00, 32'h0000007d};
        vecs[7] = '{32'h00000200, 1'b0, 32'h51f4a750, 32'h5051f4a7, 32'ha4c31a17, 32'hf4a75051};

        build_tables();

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.state     = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last",  bus.out_last,  1'b0);
        check("rst_p", {bus.p0, bus.p1, bus.p2, bus.p3}, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b1);

        // Table vectors, one at a time, with latency checks
        for (int k = 0; k < 8; k++) begin
            bus.in_valid  = 1'b1;
            bus.state     = vecs[k].state;
            bus.in_last   = vecs[k].last;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("lat1_out_valid", bus.out_valid, 1'b0);
            @(negedge clk);
            check("lat2_out_valid", bus.out_valid, 1'b1);
            check("vec_p0", bus.p0, vecs[k].e0);
            check("vec_p1", bus.p1, vecs[k].e1);
            check("vec_p2", bus.p2, vecs[k].e2);
            check("vec_p3", bus.p3, vecs[k].e3);
            check("vec_last", bus.out_last, vecs[k].last);
            @(negedge clk);
        end

        // Exhaustive normal-mode stream, back to back
        for (int b = 0; b < 256; b++) begin
            c.state = {4{b[7:0]}};
            c.last  = 1'b0;
            src_q.push_back(c);
        end
        run_stream(100000, 0, 1'b0, cycles);
        check("throughput_normal", cycles, 258);

        // Exhaustive last-mode stream, with forward S-box round trip
        for (int b = 0; b < 256; b++) begin
            c.state = {4{b[7:0]}};
            c.last  = 1'b1;
            src_q.push_back(c);
        end
        run_stream(100000, 0, 1'b1, cycles);
        check("throughput_last", cycles, 258);

        // Backpressure: 4 mixed-mode columns, consumer stalled 5 cycles
        c = '{32'h01020304, 1'b0}; src_q.push_back(c);
        c = '{32'hfedcba98, 1'b1}; src_q.push_back(c);
        c = '{32'h52096ad5, 1'b0}; src_q.push_back(c);
        c = '{32'h3036a538, 1'b1}; src_q.push_back(c);
        run_stream(2, 5, 1'b0, cycles);

        // Reset mid-stream with both stages full
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.state     = 32'h01000000;
        bus.in_last   = 1'b0;
        @(negedge clk);
        bus.state     = 32'h16161616;
        bus.in_last   = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #1;
        check("full_out_valid", bus.out_valid, 1'b1);
        check("full_in_ready",  bus.in_ready,  1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_out_valid", bus.out_valid, 1'b0);
        check("mrst_out_last",  bus.out_last,  1'b0);
        check("mrst_p", {bus.p0, bus.p1, bus.p2, bus.p3}, 128'h0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mrst_no_ghost", bus.out_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
